// File: rtl/core_pixel_agen.sv
// Tile-rotation address generator: sequences DMA load, rotated pixel copy and
// DMA store for a job of square tiles. Drives buffer addresses and strobes only.
//
// state  | meaning
// IDLE   | waiting for I_START with a non-zero tile count
// LOAD   | accepting NW input-buffer words from the DMA
// XFER   | TILE_N*TILE_N copy cycles, one pixel per cycle
// STORE  | offering NW output-buffer words to the DMA
module core_pixel_agen #(
  parameter int TILE_N    = 8,
  parameter int BPP       = 3,
  parameter int BUS_BYTES = 4,
  parameter int ADDR_W    = 8,
  parameter int WA_W      = 6
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET_N,
  input  logic              I_START,
  input  logic              I_ABORT,
  input  logic              I_DIRECTION,
  input  logic [1:0]        I_DEGREES,
  input  logic              I_MIRROR,
  input  logic [15:0]       I_TILE_CNT,
  input  logic              I_DMA_VALID,
  input  logic              I_DMA_READY,
  output logic              O_IN_WE,
  output logic [WA_W-1:0]   O_IN_WADDR,
  output logic              O_XFER_EN,
  output logic [ADDR_W-1:0] O_SRC_ADDR,
  output logic [ADDR_W-1:0] O_DST_ADDR,
  output logic              O_OUT_RE,
  output logic [WA_W-1:0]   O_OUT_WADDR,
  output logic [15:0]       O_TILE_IDX,
  output logic              O_BUSY,
  output logic              O_DONE
);

  localparam int NW  = TILE_N * TILE_N * BPP / BUS_BYTES;
  localparam int R_W = $clog2(TILE_N);
  localparam int K_W = 2 * R_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;

  logic [1:0]      state;
  logic [WA_W-1:0] wcnt;
  logic [K_W-1:0]  kcnt;
  logic [15:0]     tile_idx;
  logic [15:0]     tile_cnt_q;
  logic            dir_q;
  logic [1:0]      deg_q;
  logic            mirror_q;
  logic            done_q;
  logic [16:0]     next_idx;

  assign next_idx = {1'b0, tile_idx} + 17'd1;

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      kcnt       <= '0;
      tile_idx   <= '0;
      tile_cnt_q <= '0;
      dir_q      <= 1'b0;
      deg_q      <= 2'd0;
      mirror_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (I_ABORT) begin
        state    <= ST_IDLE;
        wcnt     <= '0;
        kcnt     <= '0;
        tile_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (I_START && (I_TILE_CNT != 16'd0)) begin
              state      <= ST_LOAD;
              tile_cnt_q <= I_TILE_CNT;
              dir_q      <= I_DIRECTION;
              deg_q      <= I_DEGREES;
              mirror_q   <= I_MIRROR;
              wcnt       <= '0;
              kcnt       <= '0;
              tile_idx   <= '0;
            end
          end
          ST_LOAD: begin
            if (I_DMA_VALID) begin
              if (wcnt == WA_W'(NW - 1)) begin
                wcnt  <= '0;
                state <= ST_XFER;
              end else begin
                wcnt <= wcnt + WA_W'(1);
              end
            end
          end
          ST_XFER: begin
            if (kcnt == K_W'(TILE_N * TILE_N - 1)) begin
              kcnt  <= '0;
              state <= ST_STORE;
            end else begin
              kcnt <= kcnt + K_W'(1);
            end
          end
          default: begin
            if (I_DMA_READY) begin
              if (wcnt == WA_W'(NW - 1)) begin
                wcnt <= '0;
                if (next_idx < {1'b0, tile_cnt_q}) begin
                  tile_idx <= tile_idx + 16'd1;
                  state    <= ST_LOAD;
                end else begin
                  tile_idx <= '0;
                  state    <= ST_IDLE;
                  done_q   <= 1'b1;
                end
              end else begin
                wcnt <= wcnt + WA_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // Edge is a power of two, so N-1-x is the bitwise complement of x.
  logic [1:0]     cw;
  logic [R_W-1:0] src_r, src_c, dst_r, dst_c;
  logic [K_W-1:0] dst_idx;

  always_comb begin
    cw    = dir_q ? 2'(2'd0 - deg_q) : deg_q;
    src_r = kcnt[K_W-1:R_W];
    src_c = kcnt[R_W-1:0];
    dst_r = src_r;
    dst_c = src_c;
    case (cw)
      2'd1: begin dst_r = src_c;  dst_c = ~src_r; end
      2'd2: begin dst_r = ~src_r; dst_c = ~src_c; end
      2'd3: begin dst_r = ~src_c; dst_c = src_r;  end
      default: begin dst_r = src_r; dst_c = src_c; end
    endcase
    if (mirror_q) dst_c = ~dst_c;
    dst_idx = {dst_r, dst_c};
  end

  assign O_IN_WE     = (state == ST_LOAD) && I_DMA_VALID;
  assign O_IN_WADDR  = (state == ST_LOAD) ? wcnt : '0;
  assign O_XFER_EN   = (state == ST_XFER);
  assign O_SRC_ADDR  = O_XFER_EN ? ADDR_W'(ADDR_W'(kcnt) * ADDR_W'(BPP)) : '0;
  assign O_DST_ADDR  = O_XFER_EN ? ADDR_W'(ADDR_W'(dst_idx) * ADDR_W'(BPP)) : '0;
  assign O_OUT_RE    = (state == ST_STORE);
  assign O_OUT_WADDR = (state == ST_STORE) ? wcnt : '0;
  assign O_TILE_IDX  = tile_idx;
  assign O_BUSY      = (state != ST_IDLE);
  assign O_DONE      = done_q;

endmodule

// File: tb/tb_core_pixel_agen.sv
// Directed bench for core_pixel_agen at default parameters (8x8 tile, 3 Bpp,
// 48 words per tile); expected values are hand-computed constants.
module tb_core_pixel_agen;

  logic        I_HCLK = 1'b0;
  logic        I_HRESET_N = 1'b0;
  logic        I_START = 1'b0;
  logic        I_ABORT = 1'b0;
  logic        I_DIRECTION = 1'b0;
  logic [1:0]  I_DEGREES = 2'd0;
  logic        I_MIRROR = 1'b0;
  logic [15:0] I_TILE_CNT = 16'd0;
  logic        I_DMA_VALID = 1'b0;
  logic        I_DMA_READY = 1'b0;
  logic        O_IN_WE;
  logic [5:0]  O_IN_WADDR;
  logic        O_XFER_EN;
  logic [7:0]  O_SRC_ADDR;
  logic [7:0]  O_DST_ADDR;
  logic        O_OUT_RE;
  logic [5:0]  O_OUT_WADDR;
  logic [15:0] O_TILE_IDX;
  logic        O_BUSY;
  logic        O_DONE;

  core_pixel_agen dut (
    .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N), .I_START(I_START), .I_ABORT(I_ABORT),
    .I_DIRECTION(I_DIRECTION), .I_DEGREES(I_DEGREES), .I_MIRROR(I_MIRROR),
    .I_TILE_CNT(I_TILE_CNT), .I_DMA_VALID(I_DMA_VALID), .I_DMA_READY(I_DMA_READY),
    .O_IN_WE(O_IN_WE), .O_IN_WADDR(O_IN_WADDR), .O_XFER_EN(O_XFER_EN),
    .O_SRC_ADDR(O_SRC_ADDR), .O_DST_ADDR(O_DST_ADDR), .O_OUT_RE(O_OUT_RE),
    .O_OUT_WADDR(O_OUT_WADDR), .O_TILE_IDX(O_TILE_IDX), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
  );

  always #5 I_HCLK = ~I_HCLK;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] dst_k [64];
  logic [7:0] src_k [64];
  int xfer_n, first_xfer, done_cyc;
  logic done_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge I_HCLK);
    #1;
  endtask

  // Cycle 1 is the first LOAD cycle, i.e. the period after the start edge.
  task automatic run_one(input logic dir, input logic [1:0] deg, input logic mir);
    I_DIRECTION = dir; I_DEGREES = deg; I_MIRROR = mir;
    I_TILE_CNT = 16'd1; I_DMA_VALID = 1'b1; I_DMA_READY = 1'b1;
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    I_DIRECTION = ~dir; I_DEGREES = ~deg; I_MIRROR = ~mir;
    xfer_n = 0; first_xfer = -1; done_cyc = -1; done_busy = 1'b1;
    for (int cyc = 2; cyc <= 400 && done_cyc < 0; cyc++) begin
      tick();
      if (O_XFER_EN) begin
        if (first_xfer < 0) first_xfer = cyc;
        if (xfer_n < 64) begin
          dst_k[xfer_n] = O_DST_ADDR;
          src_k[xfer_n] = O_SRC_ADDR;
        end
        xfer_n++;
      end
      if (O_DONE) begin
        done_cyc = cyc;
        done_busy = O_BUSY;
      end
    end
  endtask

  int in_exp, out_exp, in_bad, out_bad, in_beats, out_beats, done_n, tile_bad, tile_max;
  int post, xk, diff;
  logic [15:0] tile_prev;

  initial begin
    I_DMA_VALID = 1'b1;
    #3;
    check("reset_addr", {O_IN_WADDR, O_SRC_ADDR, O_DST_ADDR, O_OUT_WADDR}, 0);
    check("reset_ctl", {O_IN_WE, O_XFER_EN, O_OUT_RE, O_BUSY, O_DONE, O_TILE_IDX}, 0);
    #10 I_HRESET_N = 1'b1;
    I_DMA_VALID = 1'b0;
    tick();

    run_one(1'b0, 2'd1, 1'b0);
    check("cw90_k0", dst_k[0], 21);
    check("cw90_k1", dst_k[1], 45);
    check("cw90_k63", dst_k[63], 168);
    check("cw90_src63", src_k[63], 189);
    check("cw90_xfer_n", xfer_n, 64);
    check("cw90_first_xfer", first_xfer, 49);
    check("cw90_done_cyc", done_cyc, 161);
    check("cw90_done_busy", done_busy, 0);
    tick();
    check("cw90_done_pulse", O_DONE, 0);

    run_one(1'b1, 2'd1, 1'b0);
    check("ccw90_k0", dst_k[0], 168);
    check("ccw90_k7", dst_k[7], 0);

    run_one(1'b0, 2'd2, 1'b0);
    check("r180_k0", dst_k[0], 189);

    run_one(1'b0, 2'd0, 1'b1);
    check("mir0_k0", dst_k[0], 21);
    check("mir0_k8", dst_k[8], 45);

    run_one(1'b0, 2'd0, 1'b0);
    diff = 0;
    for (int i = 0; i < 64; i++) if (dst_k[i] !== src_k[i]) diff++;
    check("r0_dst_eq_src", diff, 0);
    check("r0_src5", src_k[5], 15);

    // three tiles with random handshake gaps and stray start pulses
    I_DIRECTION = 1'b0; I_DEGREES = 2'd1; I_MIRROR = 1'b0;
    I_TILE_CNT = 16'd3; I_DMA_VALID = 1'b0; I_DMA_READY = 1'b0;
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    I_TILE_CNT = 16'd7;
    in_exp = 0; out_exp = 0; in_bad = 0; out_bad = 0; in_beats = 0; out_beats = 0;
    done_n = 0; tile_bad = 0; tile_max = 0; tile_prev = 16'd0; post = 0;
    for (int cyc = 0; cyc < 4000 && post < 30; cyc++) begin
      if (cyc > 0) tick();
      if (O_DONE) done_n++;
      if (done_n > 0) post++;
      if (O_TILE_IDX !== tile_prev) begin
        if (!((O_TILE_IDX == tile_prev + 16'd1) || (O_TILE_IDX == 16'd0 && O_DONE))) tile_bad++;
        tile_prev = O_TILE_IDX;
        if (int'(O_TILE_IDX) > tile_max) tile_max = int'(O_TILE_IDX);
      end
      I_DMA_VALID = 1'($urandom_range(0, 1));
      I_DMA_READY = 1'($urandom_range(0, 1));
      I_START = O_BUSY && ($urandom_range(0, 7) == 0);
      #1;
      if (O_IN_WE) begin
        if (!I_DMA_VALID || O_IN_WADDR != 6'(in_exp)) in_bad++;
        in_exp = (in_exp == 47) ? 0 : in_exp + 1;
        in_beats++;
      end
      if (O_OUT_RE && I_DMA_READY) begin
        if (O_OUT_WADDR != 6'(out_exp)) out_bad++;
        out_exp = (out_exp == 47) ? 0 : out_exp + 1;
        out_beats++;
      end
    end
    I_START = 1'b0;
    check("multi_done_n", done_n, 1);
    check("multi_in_beats", in_beats, 144);
    check("multi_out_beats", out_beats, 144);
    check("multi_in_waddr_bad", in_bad, 0);
    check("multi_out_waddr_bad", out_bad, 0);
    check("multi_tile_max", tile_max, 2);
    check("multi_tile_seq_bad", tile_bad, 0);
    check("multi_idle_after", O_BUSY, 0);

    // abort in the second tile at k=20
    I_TILE_CNT = 16'd2; I_DMA_VALID = 1'b1; I_DMA_READY = 1'b1;
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    xk = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      tick();
      if (O_XFER_EN) begin
        if (xk == 84) break;
        xk++;
      end
    end
    check("abort_k20_src", O_SRC_ADDR, 60);
    check("abort_tile_idx", O_TILE_IDX, 1);
    I_ABORT = 1'b1;
    tick();
    I_ABORT = 1'b0;
    check("abort_busy", O_BUSY, 0);
    check("abort_ctl", {O_XFER_EN, O_DONE, O_TILE_IDX}, 0);
    done_n = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (O_DONE) done_n++;
    end
    check("abort_no_done", done_n, 0);
    I_TILE_CNT = 16'd1; I_DMA_VALID = 1'b0;
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    check("restart_busy", O_BUSY, 1);
    check("restart_tile_idx", O_TILE_IDX, 0);
    I_DMA_VALID = 1'b1;
    #1;
    check("restart_in_we", O_IN_WE, 1);
    check("restart_in_waddr", O_IN_WADDR, 0);

    // asynchronous reset in the middle of STORE
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (O_OUT_RE) break;
    end
    repeat (5) tick();
    check("pre_rst_out_re", O_OUT_RE, 1);
    check("pre_rst_out_waddr", O_OUT_WADDR, 5);
    #2 I_HRESET_N = 1'b0;
    #1;
    check("rst_mid_addr", {O_IN_WADDR, O_SRC_ADDR, O_DST_ADDR, O_OUT_WADDR}, 0);
    check("rst_mid_ctl", {O_IN_WE, O_XFER_EN, O_OUT_RE, O_BUSY, O_DONE, O_TILE_IDX}, 0);
    #3 I_HRESET_N = 1'b1;
    tick();

    // zero tile count and start together with abort are both ignored
    I_TILE_CNT = 16'd0;
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    check("cnt0_busy", O_BUSY, 0);
    repeat (3) tick();
    check("cnt0_busy_later", {O_BUSY, O_IN_WE}, 0);
    I_TILE_CNT = 16'd1;
    I_START = 1'b1; I_ABORT = 1'b1;
    tick();
    I_START = 1'b0; I_ABORT = 1'b0;
    check("start_abort_idle", O_BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_pixel_agen.md
# core_pixel_agen

Parametrised tile-rotation address generator, successor to the fixed 8x8/RGB pixel address core. Sequences one or more square tiles through three phases: DMA load into the input buffer, rotation copy from input buffer to output buffer, and DMA store from the output buffer. The copy phase implements 0/90/180/270 degree rotation in either direction plus an optional horizontal mirror. It sits between the AHB DMA engine and the two tile buffers and drives only addresses and strobes; data paths are outside this block.

## Interface
- TILE_N, 8, tile edge in pixels; power of 2, 4..16
- BPP, 3, bytes per pixel; 1..4
- BUS_BYTES, 4, bytes per DMA word; TILE_N*TILE_N*BPP must be a multiple of BUS_BYTES
- ADDR_W, 8, buffer byte-address width; 2^ADDR_W >= TILE_N*TILE_N*BPP
- WA_W, 6, word-address width; 2^WA_W >= NW, where NW = TILE_N*TILE_N*BPP/BUS_BYTES
- I_HCLK  in  1  clock; all logic on rising edge
- I_HRESET_N  in  1  asynchronous active-low reset
- I_START  in  1  start pulse; sampled in IDLE only
- I_ABORT  in  1  synchronous abort, any state
- I_DIRECTION  in  1  1 = counter-clockwise, 0 = clockwise
- I_DEGREES  in  2  0/1/2/3 = 0/90/180/270 degrees
- I_MIRROR  in  1  horizontal flip applied after rotation
- I_TILE_CNT  in  16  tiles per job; 0 means I_START is ignored
- I_DMA_VALID  in  1  DMA load beat present
- I_DMA_READY  in  1  DMA accepts store beat
- O_IN_WE  out  1  input-buffer word write strobe
- O_IN_WADDR  out  WA_W  input-buffer word address
- O_XFER_EN  out  1  copy strobe, one pixel per cycle
- O_SRC_ADDR  out  ADDR_W  input-buffer pixel base byte address; channels at +0..BPP-1
- O_DST_ADDR  out  ADDR_W  output-buffer pixel base byte address
- O_OUT_RE  out  1  output-buffer word read strobe
- O_OUT_WADDR  out  WA_W  output-buffer word address
- O_TILE_IDX  out  16  index of the current tile
- O_BUSY  out  1  high in any state other than IDLE
- O_DONE  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, LOAD, XFER, STORE.
- IDLE -> LOAD on I_START with I_TILE_CNT != 0. I_DIRECTION, I_DEGREES, I_MIRROR and I_TILE_CNT are latched at this point; input changes while busy are ignored.
- LOAD: O_IN_WE = I_DMA_VALID (combinational). The word counter increments per accepted beat. The last accepted beat (counter = NW-1) moves to XFER and clears the counter.
- XFER: exactly TILE_N*TILE_N cycles with O_XFER_EN = 1 and no stalls. Pixel counter k runs 0..TILE_N^2-1.
  - Source index r = k / TILE_N, c = k % TILE_N. O_SRC_ADDR = k*BPP.
  - Effective clockwise angle: cw = DIRECTION ? (4-DEG) mod 4 : DEG.
  - Destination (r', c') by cw: 0 -> (r, c); 90 -> (c, N-1-r); 180 -> (N-1-r, N-1-c); 270 -> (N-1-c, r).
  - If mirror is set, c' = N-1-c'.
  - O_DST_ADDR = (r'*TILE_N + c')*BPP, computed combinationally from k and the latched mode.
- STORE: O_OUT_RE = 1; O_OUT_WADDR = store word counter. The counter advances when I_DMA_READY = 1. On the last accepted word:
  - if O_TILE_IDX+1 < latched count: go to LOAD and increment O_TILE_IDX;
  - otherwise: go to IDLE, pulse O_DONE, and reset O_TILE_IDX to 0.
- I_ABORT (highest priority): next state is IDLE, all counters clear, no O_DONE. An abort in IDLE has no effect.
- I_START while busy is ignored. I_START together with I_ABORT in IDLE: abort wins and the block stays in IDLE.

## Timing
- Reset values: state IDLE, all counters 0, latched mode 0. All outputs are 0, including O_SRC_ADDR and O_DST_ADDR.
- Outputs other than O_IN_WE and the address outputs are decoded from the registered state. O_DONE is registered.
- I_START is sampled at edge t; LOAD occupies t+1.
- XFER starts the cycle after the last LOAD beat. STORE starts the cycle after k = TILE_N^2-1.
- O_DONE is high in the cycle after the final STORE accept, coinciding with IDLE and O_BUSY = 0.
- Stall-free tile duration: 2*NW + TILE_N^2 cycles (160 at the defaults).
- The word counters wrap only through explicit clear, never through arithmetic overflow.
- An asynchronous reset mid-job returns the block to reset values immediately.

## Test plan
- Defaults, cw 90, no mirror, 1 tile, stall-free. Required:
  - k=0 -> DST 21; k=1 -> DST 45; k=63 -> DST 168;
  - O_DONE at cycle 161 after start.
- CCW 90 (same as cw 270): k=0 -> DST 168 (0xA8); k=7 -> DST 0. 180 degrees: k=0 -> DST 189 (0xBD).
- 0 degrees with mirror: k=0 -> DST 21; k=8 -> DST 45. 0 degrees without mirror: DST == SRC for all k.
- 3 tiles with random VALID/READY gaps:
  - O_IN_WADDR 0..47 per tile, advancing only on VALID;
  - O_TILE_IDX 0 -> 1 -> 2;
  - exactly one O_DONE; I_START pulses while busy have no effect.
- I_ABORT at XFER k=20: IDLE next cycle, no O_DONE. A following start begins at O_IN_WADDR 0 and O_TILE_IDX 0.
- Reset asserted mid-STORE: all outputs 0 immediately. I_TILE_CNT=0 with I_START: stays IDLE, O_BUSY stays 0.
